// File: rtl/kinase_valve_sequencer.sv
// Loadable valve/pump step sequencer for the kinase assay chip family.
// Runs a stored program of valve masks and dwells, then always flushes.
module kinase_valve_sequencer #(
  parameter int CTRL_W    = 13,
  parameter int SEL_W     = 4,
  parameter int PUMP_N    = 2,
  parameter int DEPTH     = 16,
  parameter int DWELL_W   = 16,
  parameter int PUMP_DIV  = 4,
  parameter int FLUSH_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [CTRL_W-1:0]          prog_ctrl,
  input  logic [SEL_W-1:0]           prog_sel,
  input  logic [PUMP_N-1:0]          prog_pump,
  input  logic [DWELL_W-1:0]         prog_dwell,
  input  logic                       prog_last,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [CTRL_W-1:0]          ctrl_valve,
  output logic [SEL_W-1:0]           sel_valve,
  output logic [3*PUMP_N-1:0]        pump_valve,
  output logic                       flush_en
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  logic [CTRL_W-1:0]  ctrl_mem  [DEPTH];
  logic [SEL_W-1:0]   sel_mem   [DEPTH];
  logic [PUMP_N-1:0]  pump_mem  [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];
  logic               last_mem  [DEPTH];

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [AW-1:0]      step_idx_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [SEL_W-1:0]   sel_q;
  logic [3*PUMP_N-1:0] pump_q;
  logic               flush_q;
  logic [PUMP_N-1:0]  pump_en_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               last_q;
  logic [1:0]         phase_q;
  logic [DW-1:0]      div_q;
  logic [FW-1:0]      flush_cnt_q;

  logic [AW-1:0]      fetch_idx_d;
  logic [DWELL_W-1:0] fetch_dwell_d;
  logic               phase_adv_d;
  logic [1:0]         phase_d;
  logic [DW-1:0]      div_d;
  logic               step_end_d;
  logic               to_flush_d;

  function automatic logic [3*PUMP_N-1:0] drive(
    input logic [PUMP_N-1:0] en,
    input logic [1:0]        ph
  );
    logic [2:0] pat;
    case (ph)
      2'd0:    pat = 3'b110;
      2'd1:    pat = 3'b011;
      default: pat = 3'b101;
    endcase
    drive = '0;
    for (int p = 0; p < PUMP_N; p++) begin
      if (en[p]) drive[3*p +: 3] = pat;
    end
  endfunction

  // Program store has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      ctrl_mem[prog_addr]  <= prog_ctrl;
      sel_mem[prog_addr]   <= prog_sel;
      pump_mem[prog_addr]  <= prog_pump;
      dwell_mem[prog_addr] <= prog_dwell;
      last_mem[prog_addr]  <= prog_last;
    end
  end

  always_comb begin
    fetch_idx_d = '0;
    if (state_q == S_RUN) fetch_idx_d = step_idx_q + AW'(1);
    fetch_dwell_d = dwell_mem[fetch_idx_d];
    if (fetch_dwell_d == '0) fetch_dwell_d = DWELL_W'(1);
    phase_adv_d = (div_q == DW'(PUMP_DIV - 1));
    div_d       = phase_adv_d ? '0 : div_q + DW'(1);
    phase_d     = phase_q;
    if (phase_adv_d) phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    step_end_d  = (dwell_q == DWELL_W'(1));
    to_flush_d  = abort || (step_end_d &&
                  (last_q || step_idx_q == AW'(DEPTH - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_idx_q  <= '0;
      ctrl_q      <= '0;
      sel_q       <= '0;
      pump_q      <= '0;
      flush_q     <= 1'b0;
      pump_en_q   <= '0;
      dwell_q     <= '0;
      last_q      <= 1'b0;
      phase_q     <= '0;
      div_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            step_idx_q <= '0;
            ctrl_q     <= ctrl_mem[fetch_idx_d];
            sel_q      <= sel_mem[fetch_idx_d];
            pump_en_q  <= pump_mem[fetch_idx_d];
            pump_q     <= drive(pump_mem[fetch_idx_d], 2'd0);
            dwell_q    <= fetch_dwell_d;
            last_q     <= last_mem[fetch_idx_d];
            phase_q    <= '0;
            div_q      <= '0;
          end
        end
        S_RUN: begin
          phase_q <= phase_d;
          div_q   <= div_d;
          if (to_flush_d) begin
            state_q     <= S_FLUSH;
            ctrl_q      <= '0;
            sel_q       <= '0;
            pump_q      <= '0;
            flush_q     <= 1'b1;
            flush_cnt_q <= FW'(FLUSH_CYC);
          end else if (step_end_d) begin
            step_idx_q <= fetch_idx_d;
            ctrl_q     <= ctrl_mem[fetch_idx_d];
            sel_q      <= sel_mem[fetch_idx_d];
            pump_en_q  <= pump_mem[fetch_idx_d];
            pump_q     <= drive(pump_mem[fetch_idx_d], phase_d);
            dwell_q    <= fetch_dwell_d;
            last_q     <= last_mem[fetch_idx_d];
          end else begin
            dwell_q <= dwell_q - DWELL_W'(1);
            pump_q  <= drive(pump_en_q, phase_d);
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == FW'(1)) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            flush_q    <= 1'b0;
            step_idx_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign step_idx   = step_idx_q;
  assign ctrl_valve = ctrl_q;
  assign sel_valve  = sel_q;
  assign pump_valve = pump_q;
  assign flush_en   = flush_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: random programs checked cycle by
// cycle against a trace built from the step/dwell/flush rules.
module tb_kinase_valve_sequencer;

  localparam int CTRL_W    = 13;
  localparam int SEL_W     = 4;
  localparam int PUMP_N    = 2;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int DWELL_W   = 16;
  localparam int PUMP_DIV  = 4;
  localparam int FLUSH_CYC = 8;

  logic clk;
  logic rst;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [CTRL_W-1:0] prog_ctrl;
  logic [SEL_W-1:0] prog_sel;
  logic [PUMP_N-1:0] prog_pump;
  logic [DWELL_W-1:0] prog_dwell;
  logic prog_last;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [AW-1:0] step_idx;
  logic [CTRL_W-1:0] ctrl_valve;
  logic [SEL_W-1:0] sel_valve;
  logic [3*PUMP_N-1:0] pump_valve;
  logic flush_en;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              flush;
    logic [AW-1:0]     idx;
    logic [CTRL_W-1:0] ctrl;
    logic [SEL_W-1:0]  sel;
    logic [3*PUMP_N-1:0] pump;
  } obs_t;

  obs_t obs;
  assign obs = {busy, done, flush_en, step_idx,
                ctrl_valve, sel_valve, pump_valve};

  logic [CTRL_W-1:0] m_ctrl [DEPTH];
  logic [SEL_W-1:0]  m_sel  [DEPTH];
  logic [PUMP_N-1:0] m_pump [DEPTH];
  int                m_dwell[DEPTH];
  bit                m_last [DEPTH];
  obs_t              exp_q[$];
  int                n_checks;
  int                n_fail;

  kinase_valve_sequencer #(
    .CTRL_W(CTRL_W), .SEL_W(SEL_W), .PUMP_N(PUMP_N),
    .DEPTH(DEPTH), .DWELL_W(DWELL_W), .PUMP_DIV(PUMP_DIV),
    .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_ctrl(prog_ctrl), .prog_sel(prog_sel),
    .prog_pump(prog_pump), .prog_dwell(prog_dwell),
    .prog_last(prog_last), .start(start), .abort(abort),
    .busy(busy), .done(done), .step_idx(step_idx),
    .ctrl_valve(ctrl_valve), .sel_valve(sel_valve),
    .pump_valve(pump_valve), .flush_en(flush_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*PUMP_N-1:0] pump_model(
    input logic [PUMP_N-1:0] en, input int cyc);
    logic [2:0] pats [3];
    logic [3*PUMP_N-1:0] r;
    pats = '{3'b110, 3'b011, 3'b101};
    r = '0;
    for (int p = 0; p < PUMP_N; p++)
      if (en[p]) r[3*p +: 3] = pats[(cyc / PUMP_DIV) % 3];
    return r;
  endfunction

  // Expected per-cycle outputs from the first RUN cycle to the done cycle.
  task automatic build(input int abort_at);
    obs_t e;
    int c;
    bit stop;
    c = 0;
    stop = 0;
    exp_q.delete();
    for (int k = 0; k < DEPTH && !stop; k++) begin
      int d;
      d = (m_dwell[k] == 0) ? 1 : m_dwell[k];
      for (int r = 0; r < d && !stop; r++) begin
        e = '0;
        e.busy = 1'b1;
        e.idx = AW'(k);
        e.ctrl = m_ctrl[k];
        e.sel = m_sel[k];
        e.pump = pump_model(m_pump[k], c);
        exp_q.push_back(e);
        if (c == abort_at) stop = 1;
        c++;
      end
      if (m_last[k]) stop = 1;
    end
    for (int f = 0; f < FLUSH_CYC; f++) begin
      e = '0;
      e.busy = 1'b1;
      e.flush = 1'b1;
      exp_q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic load_all();
    for (int a = 0; a < DEPTH; a++) begin
      prog_we = 1'b1;
      prog_addr = AW'(a);
      prog_ctrl = m_ctrl[a];
      prog_sel = m_sel[a];
      prog_pump = m_pump[a];
      prog_dwell = DWELL_W'(m_dwell[a]);
      prog_last = m_last[a];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic rand_prog(input int maxdw, input int lastpos);
    for (int k = 0; k < DEPTH; k++) begin
      m_ctrl[k] = CTRL_W'($urandom);
      m_sel[k] = SEL_W'($urandom);
      m_pump[k] = PUMP_N'($urandom);
      m_dwell[k] = $urandom_range(0, maxdw);
      m_last[k] = (k == lastpos);
    end
  endtask

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want 0", obs);
    end
    rand_prog(0, 3);
    for (int k = 0; k < 4; k++) m_dwell[k] = 3;
    load_all();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (step_idx !== AW'(2) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: got idx %0d busy %b want 2 1",
               step_idx, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h want 0", obs);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy || flush_en) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    end
    build(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      obs_t o;
      o = obs;
      if (exp_q[i].flush) o.idx = exp_q[i].idx;
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_rerun c%0d: got %h want %h", i, o, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_three_step();
    rand_prog(0, 2);
    m_dwell[0] = 3;
    m_dwell[1] = 0;
    m_dwell[2] = 5;
    load_all();
    build(-1);
    n_checks++;
    if (exp_q.size() != 18) begin
      n_fail++;
      $display("FAIL three_len: got %0d want 18", exp_q.size());
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      obs_t o;
      o = obs;
      if (exp_q[i].flush) o.idx = exp_q[i].idx;
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL three_step c%0d: got %h want %h", i, o, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_pump();
    rand_prog(0, 0);
    m_dwell[0] = 12;
    m_pump[0] = 2'b01;
    load_all();
    build(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      obs_t o;
      o = obs;
      if (exp_q[i].flush) o.idx = exp_q[i].idx;
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pump c%0d: got %h want %h", i, o, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    rand_prog(4, 1);
    m_dwell[0] = 10;
    load_all();
    build(1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    foreach (exp_q[i]) begin
      obs_t o;
      o = obs;
      if (exp_q[i].flush) o.idx = exp_q[i].idx;
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort c%0d: got %h want %h", i, o, exp_q[i]);
      end
      abort = (i == 1 || i == 5);
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_full_depth();
    rand_prog(0, -1);
    for (int k = 0; k < DEPTH; k++) m_dwell[k] = 1;
    load_all();
    build(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    foreach (exp_q[i]) begin
      obs_t o;
      o = obs;
      if (exp_q[i].flush) o.idx = exp_q[i].idx;
      n_checks++;
      if (o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_depth c%0d: got %h want %h", i, o, exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_protection();
    rand_prog(5, 5);
    load_all();
    build(-1);
    for (int pass = 0; pass < 2; pass++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      foreach (exp_q[i]) begin
        obs_t o;
        o = obs;
        if (exp_q[i].flush) o.idx = exp_q[i].idx;
        n_checks++;
        if (o !== exp_q[i]) begin
          n_fail++;
          $display("FAIL protect p%0d c%0d: got %h want %h",
                   pass, i, o, exp_q[i]);
        end
        prog_we = (pass == 0) && (i < exp_q.size() - 1);
        start = (pass == 0) && (i < exp_q.size() - 1);
        prog_addr = AW'(i % 3);
        prog_ctrl = ~m_ctrl[i % 3];
        prog_sel = ~m_sel[i % 3];
        prog_pump = ~m_pump[i % 3];
        prog_dwell = 16'd7;
        prog_last = 1'b1;
        tick();
      end
      prog_we = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    rand_prog(6, 3);
    load_all();
    build(-1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      foreach (exp_q[i]) begin
        obs_t o;
        o = obs;
        if (exp_q[i].flush) o.idx = exp_q[i].idx;
        n_checks++;
        if (o !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b p%0d c%0d: got %h want %h",
                   pass, i, o, exp_q[i]);
        end
        start = (pass == 0) && (i == exp_q.size() - 1);
        tick();
      end
      start = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len;
      int ab;
      rand_prog(6, $urandom_range(0, DEPTH - 1));
      load_all();
      build(-1);
      len = exp_q.size() - FLUSH_CYC - 1;
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      build(ab);
      start = 1'b1;
      tick();
      start = 1'b0;
      foreach (exp_q[i]) begin
        obs_t o;
        o = obs;
        if (exp_q[i].flush) o.idx = exp_q[i].idx;
        n_checks++;
        if (o !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random it%0d c%0d: got %h want %h",
                   it, i, o, exp_q[i]);
        end
        abort = (i == ab);
        tick();
      end
      abort = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_ctrl = '0;
    prog_sel = '0;
    prog_pump = '0;
    prog_dwell = '0;
    prog_last = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    test_reset();
    test_three_step();
    test_pump();
    test_abort();
    test_full_depth();
    test_protection();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
